// File: rtl/pa_arbiter_ctrl.sv
// Round-robin arbiter that shares one registered ripple adder slice among NREQ requesters.
// Optional subtract mode (A-B via ~B and carry-in 1) is enabled by defining PA_ARB_SUB_EN.
module pa_arbiter_ctrl #(
   parameter int NREQ = 2,
   parameter int W    = 4,
   parameter int LAT  = 4,
   parameter int IDW  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   input  logic [NREQ-1:0]   req_cin,
`ifdef PA_ARB_SUB_EN
   input  logic [NREQ-1:0]   req_sub,
   output logic              rsp_sub,
`endif
   output logic [W-1:0]      add_a,
   output logic [W-1:0]      add_b,
   output logic              add_cin,
   output logic              add_reset,
   input  logic [W-1:0]      add_sum,
   input  logic              add_carry,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [W-1:0]      rsp_sum,
   output logic              rsp_carry,
   output logic              busy
);

   localparam int CW = ($clog2(LAT) > 0) ? $clog2(LAT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] gnt_idx;
   logic           gnt_any;
   logic [IDW:0]   scan;
   logic [IDW-1:0] idx;
   logic [W-1:0]   gnt_a;
   logic [W-1:0]   gnt_b;
   logic           gnt_cin;
   logic [IDW-1:0] rr_next;

   // Search upward from rr_ptr with wrap; only IDLE can grant, so the grant is also the handshake.
   always_comb begin
      req_ready = '0;
      gnt_idx   = '0;
      gnt_any   = 1'b0;
      scan      = '0;
      idx       = '0;
      if (state == IDLE) begin
         for (int i = 0; i < NREQ; i++) begin
            scan = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (scan >= (IDW+1)'(NREQ))
               scan = scan - (IDW+1)'(NREQ);
            idx = scan[IDW-1:0];
            if (!gnt_any && req_valid[idx]) begin
               gnt_any        = 1'b1;
               gnt_idx        = idx;
               req_ready[idx] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      gnt_a   = req_a[int'(gnt_idx)*W +: W];
      gnt_b   = req_b[int'(gnt_idx)*W +: W];
      gnt_cin = req_cin[gnt_idx];
`ifdef PA_ARB_SUB_EN
      if (req_sub[gnt_idx]) begin
         gnt_b   = ~req_b[int'(gnt_idx)*W +: W];
         gnt_cin = 1'b1;
      end
`endif
      rr_next = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
   end

   // add_reset stays high in IDLE so the adder is cleared on the very edge that latches operands.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         rr_ptr    <= '0;
         add_a     <= '0;
         add_b     <= '0;
         add_cin   <= 1'b0;
         add_reset <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_sum   <= '0;
         rsp_carry <= 1'b0;
         busy      <= 1'b0;
`ifdef PA_ARB_SUB_EN
         rsp_sub   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (gnt_any) begin
                  add_a     <= gnt_a;
                  add_b     <= gnt_b;
                  add_cin   <= gnt_cin;
                  rsp_id    <= gnt_idx;
                  rr_ptr    <= rr_next;
                  cnt       <= '0;
                  add_reset <= 1'b0;
                  busy      <= 1'b1;
`ifdef PA_ARB_SUB_EN
                  rsp_sub   <= req_sub[gnt_idx];
`endif
                  state     <= RUN;
               end
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  rsp_sum   <= add_sum;
                  rsp_carry <= add_carry;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  add_reset <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pa_arbiter_ctrl.sv
// Scoreboard bench for pa_arbiter_ctrl: directed scenarios plus random traffic against a
// transaction-level model; includes an ideal registered adder standing in for the slice.
module tb_pa_arbiter_ctrl;

   localparam int NREQ = 2;
   localparam int W    = 4;
   localparam int LAT  = 4;
   localparam int IDW  = 1;
   localparam int AW   = NREQ * W;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [NREQ-1:0] req_valid = '0;
   logic [NREQ-1:0] req_ready;
   logic [AW-1:0]   req_a = '0;
   logic [AW-1:0]   req_b = '0;
   logic [NREQ-1:0] req_cin = '0;
   logic [NREQ-1:0] req_sub = '0;
   logic [W-1:0]    add_a;
   logic [W-1:0]    add_b;
   logic            add_cin;
   logic            add_reset;
   logic [W-1:0]    add_sum;
   logic            add_carry;
   logic            rsp_valid;
   logic            rsp_ready = 1'b0;
   logic [IDW-1:0]  rsp_id;
   logic [W-1:0]    rsp_sum;
   logic            rsp_carry;
   logic            busy;
`ifdef PA_ARB_SUB_EN
   logic            rsp_sub;
`endif

   pa_arbiter_ctrl #(.NREQ(NREQ), .W(W), .LAT(LAT), .IDW(IDW)) dut (
      .clk(clk),
      .reset(reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_a(req_a),
      .req_b(req_b),
      .req_cin(req_cin),
`ifdef PA_ARB_SUB_EN
      .req_sub(req_sub),
      .rsp_sub(rsp_sub),
`endif
      .add_a(add_a),
      .add_b(add_b),
      .add_cin(add_cin),
      .add_reset(add_reset),
      .add_sum(add_sum),
      .add_carry(add_carry),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_id(rsp_id),
      .rsp_sum(rsp_sum),
      .rsp_carry(rsp_carry),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Stand-in adder slice: synchronous clear, otherwise registers the full sum every edge.
   always @(posedge clk) begin
      if (add_reset)
         {add_carry, add_sum} <= '0;
      else
         {add_carry, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
   end

   typedef struct {
      int           id;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W:0]   res;
      int           due;
   } exp_t;

   exp_t sbq[$];
   int   compared = 0;
   int   mismatched = 0;
   int   cycle = 0;
   bit   m_idle = 1'b1;
   int   m_rr = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cycle, act, exp);
      end
   endtask

   function automatic int pickGrant(input logic [NREQ-1:0] v, input int rr);
      for (int k = 0; k < NREQ; k++)
         if (v[(rr + k) % NREQ])
            return (rr + k) % NREQ;
      return -1;
   endfunction

   // Monitor: derives every expected output from the model state, then advances the model.
   always @(negedge clk) begin : monitor
      int           g;
      logic [31:0]  er;
      logic         ev;
      logic [W-1:0] ga;
      logic [W-1:0] gb;
      logic         gc;
      logic         gs;
      exp_t         e;
      cycle++;
      if (!reset) begin
         sbq.delete();
         m_idle = 1'b1;
         m_rr   = 0;
         checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
         checkOutput("rst_busy", 32'(busy), 0);
         checkOutput("rst_add_reset", 32'(add_reset), 1);
         checkOutput("rst_add_a", 32'(add_a), 0);
         checkOutput("rst_add_b", 32'(add_b), 0);
         checkOutput("rst_add_cin", 32'(add_cin), 0);
         checkOutput("rst_rsp_sum", 32'(rsp_sum), 0);
         checkOutput("rst_rsp_id", 32'(rsp_id), 0);
         checkOutput("rst_rsp_carry", 32'(rsp_carry), 0);
`ifdef PA_ARB_SUB_EN
         checkOutput("rst_rsp_sub", 32'(rsp_sub), 0);
`endif
      end else begin
         g  = m_idle ? pickGrant(req_valid, m_rr) : -1;
         er = (g >= 0) ? (32'd1 << g) : 32'd0;
         checkOutput("req_ready", 32'(req_ready), er);
         checkOutput("busy", 32'(busy), 32'(!m_idle));
         checkOutput("add_reset", 32'(add_reset), 32'(m_idle));
         if (!m_idle && sbq.size() > 0) begin
            e = sbq[0];
            checkOutput("add_a", 32'(add_a), 32'(e.a));
            checkOutput("add_b", 32'(add_b), 32'(e.b));
            checkOutput("add_cin", 32'(add_cin), 32'(e.cin));
         end
         ev = (sbq.size() > 0) && (cycle >= sbq[0].due);
         checkOutput("rsp_valid", 32'(rsp_valid), 32'(ev));
         if (ev) begin
            e = sbq[0];
            checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
            checkOutput("rsp_sum", 32'(rsp_sum), 32'(e.res[W-1:0]));
            checkOutput("rsp_carry", 32'(rsp_carry), 32'(e.res[W]));
`ifdef PA_ARB_SUB_EN
            checkOutput("rsp_sub", 32'(rsp_sub), 32'(e.sub));
`endif
            if (rsp_ready) begin
               void'(sbq.pop_front());
               m_idle = 1'b1;
            end
         end
         if (g >= 0) begin
            ga = req_a[g*W +: W];
            gb = req_b[g*W +: W];
            gc = req_cin[g];
`ifdef PA_ARB_SUB_EN
            gs = req_sub[g];
`else
            gs = 1'b0;
`endif
            if (gs) begin
               gb = ~gb;
               gc = 1'b1;
            end
            e.id  = g;
            e.a   = ga;
            e.b   = gb;
            e.cin = gc;
            e.sub = gs;
            e.res = {1'b0, ga} + {1'b0, gb} + (W+1)'(gc);
            e.due = cycle + LAT + 1;
            sbq.push_back(e);
            m_idle = 1'b0;
            m_rr   = (g + 1) % NREQ;
         end
      end
   end

   // Called at posedge+1; drives the inputs and holds them for the given number of cycles.
   task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [AW-1:0] a,
                                input logic [AW-1:0] b, input logic [NREQ-1:0] cin,
                                input logic [NREQ-1:0] sub, input logic rdy, input int cycles);
      req_valid = v;
      req_a     = a;
      req_b     = b;
      req_cin   = cin;
      req_sub   = sub;
      rsp_ready = rdy;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus('0, '0, '0, '0, '0, 1'b1, 2);

      $display("[TB] single add on requester 0");
      applyStimulus(2'b01, {4'h0, 4'h7}, {4'h0, 4'h9}, 2'b00, 2'b00, 1'b1, 1);
      applyStimulus('0, '0, '0, '0, '0, 1'b1, 8);

      $display("[TB] both requesters streaming");
      applyStimulus(2'b11, {4'hF, 4'h7}, {4'h1, 4'h9}, 2'b10, 2'b00, 1'b1, 30);
      applyStimulus('0, '0, '0, '0, '0, 1'b1, 8);

      $display("[TB] response backpressure");
      applyStimulus(2'b01, {4'h2, 4'hC}, {4'h3, 4'h5}, 2'b01, 2'b00, 1'b0, 1);
      applyStimulus(2'b11, {4'h2, 4'hC}, {4'h3, 4'h5}, 2'b01, 2'b00, 1'b0, 10);
      applyStimulus(2'b11, {4'h2, 4'hC}, {4'h3, 4'h5}, 2'b01, 2'b00, 1'b1, 3);
      applyStimulus('0, '0, '0, '0, '0, 1'b1, 8);

      $display("[TB] reset in the middle of an operation");
      applyStimulus(2'b01, {4'h0, 4'h6}, {4'h0, 4'h6}, 2'b00, 2'b00, 1'b1, 1);
      applyStimulus('0, '0, '0, '0, '0, 1'b1, 2);
      #1 reset = 1'b0;
      @(posedge clk);
      #2 reset = 1'b1;
      applyStimulus(2'b11, {4'h4, 4'hA}, {4'h1, 4'h7}, 2'b00, 2'b00, 1'b1, 1);
      applyStimulus('0, '0, '0, '0, '0, 1'b1, 8);

`ifdef PA_ARB_SUB_EN
      $display("[TB] subtract on requester 0");
      applyStimulus(2'b01, {4'h0, 4'h3}, {4'h0, 4'h5}, 2'b00, 2'b01, 1'b1, 1);
      applyStimulus('0, '0, '0, '0, '0, 1'b1, 8);
`endif

      $display("[TB] random traffic");
      for (int n = 0; n < 400; n++) begin
         applyStimulus(NREQ'($urandom), AW'($urandom), AW'($urandom), NREQ'($urandom),
                       NREQ'($urandom), ($urandom_range(0, 3) != 0), 1);
      end

      applyStimulus('0, '0, '0, '0, '0, 1'b1, 12);
      @(negedge clk);
      checkOutput("scoreboard_empty", 32'(sbq.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
